// File: rtl/itc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : itc_ctrl_pkg
// Description : Register map, bit positions and FSM encoding for the
//               clocked-video-output control master.
// Revision    : 1.0 - initial release
// ============================================================================
package itc_ctrl_pkg;

    localparam int c_addr_w = 8;
    localparam int c_data_w = 16;

    localparam logic [c_addr_w-1:0] c_addr_ctrl   = 8'd0;
    localparam logic [c_addr_w-1:0] c_addr_status = 8'd1;
    localparam logic [c_addr_w-1:0] c_addr_int    = 8'd2;
    localparam logic [c_addr_w-1:0] c_addr_usedw  = 8'd3;
    localparam logic [c_addr_w-1:0] c_addr_mode   = 8'd4;

    localparam int c_st_resync    = 0;
    localparam int c_st_uflow     = 2;
    localparam int c_st_genlocked = 3;
    localparam int c_int_pend_lsb = 1;

    localparam logic [c_data_w-1:0] c_uflow_clear = 16'h0004;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CFG       = 4'd1,
        S_RUN       = 4'd2,
        S_RD_STATUS = 4'd3,
        S_CLR_UF    = 4'd4,
        S_RD_USEDW  = 4'd5,
        S_RD_INT    = 4'd6,
        S_RD_MODE   = 4'd7,
        S_CLR_INT   = 4'd8,
        S_DISABLE   = 4'd9
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/itc_avmm_xact.sv
`default_nettype none
// ============================================================================
// Module      : itc_avmm_xact
// Description : Single-command Avalon-MM issuer; holds a request until
//               accepted and inserts one idle cycle after every accept.
// Revision    : 1.0 - initial release
// ============================================================================
module itc_avmm_xact
    import itc_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic                i_req_write,
    input  logic [c_addr_w-1:0] i_req_addr,
    input  logic [c_data_w-1:0] i_req_wdata,
    output logic [c_addr_w-1:0] o_av_address,
    output logic                o_av_read,
    output logic                o_av_write,
    output logic [c_data_w-1:0] o_av_writedata,
    input  logic [c_data_w-1:0] i_av_readdata,
    input  logic                i_av_waitrequest,
    output logic                o_accept,
    output logic [c_data_w-1:0] o_rdata
);

    logic r_gap;
    logic w_issue;

    // Request fields come from registered FSM state, so they are stable under stall.
    assign w_issue        = i_req & ~r_gap;
    assign o_av_read      = w_issue & ~i_req_write;
    assign o_av_write     = w_issue & i_req_write;
    assign o_av_address   = i_req_addr;
    assign o_av_writedata = i_req_wdata;
    assign o_accept       = w_issue & ~i_av_waitrequest;
    assign o_rdata        = i_av_readdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap <= 1'b0;
        end else begin
            r_gap <= o_accept;
        end
    end

endmodule
`default_nettype wire

// File: rtl/itc_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : itc_ctrl_master
// Description : CPU-less controller for the clocked-video-output control
//               slave: enable, status polling, underflow clear, interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module itc_ctrl_master
    import itc_ctrl_pkg::*;
#(
    parameter logic [1:0] INT_MASK         = 2'b01,
    parameter logic [1:0] GENLOCK_EN       = 2'b00,
    parameter int         POLL_INTERVAL    = 1024,
    parameter int         UNDERFLOW_CLEAR  = 1,
    parameter int         USED_WORDS_WIDTH = 15,
    parameter int         NO_OF_MODES_INT  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        irq,
    output logic [7:0]                  av_address,
    output logic                        av_read,
    output logic                        av_write,
    output logic [15:0]                 av_writedata,
    input  logic [15:0]                 av_readdata,
    input  logic                        av_waitrequest,
    output logic                        running,
    output logic [USED_WORDS_WIDTH-1:0] fill_level,
    output logic                        genlocked,
    output logic                        resync,
    output logic [NO_OF_MODES_INT-1:0]  mode_match,
    output logic                        mode_valid,
    output logic [7:0]                  underflow_count
);

    localparam int                   c_cnt_w    = $clog2(POLL_INTERVAL);
    localparam logic [c_cnt_w-1:0]   c_cnt_max  = c_cnt_w'(POLL_INTERVAL - 1);
    localparam logic [c_data_w-1:0]  c_ctrl_on  = {11'd0, GENLOCK_EN, INT_MASK, 1'b1};
    localparam logic [c_data_w-1:0]  c_ctrl_off = {11'd0, GENLOCK_EN, INT_MASK, 1'b0};

    state_t                      r_state;
    state_t                      w_next;
    logic [c_cnt_w-1:0]          r_cnt;
    logic                        r_stop_pend;
    logic                        r_running;
    logic [USED_WORDS_WIDTH-1:0] r_fill;
    logic                        r_genlocked;
    logic                        r_resync;
    logic [NO_OF_MODES_INT-1:0]  r_mode;
    logic                        r_mode_valid;
    logic [7:0]                  r_uf_cnt;
    logic [1:0]                  r_pend;

    logic                        w_req;
    logic                        w_req_write;
    logic [c_addr_w-1:0]         w_addr;
    logic [c_data_w-1:0]         w_wdata;
    logic                        w_accept;
    logic [c_data_w-1:0]         w_rdata;
    logic [1:0]                  w_pend;

    assign w_pend = w_rdata[c_int_pend_lsb +: 2];

    itc_avmm_xact u_xact (
        .clk              (clk),
        .rst              (rst),
        .i_req            (w_req),
        .i_req_write      (w_req_write),
        .i_req_addr       (w_addr),
        .i_req_wdata      (w_wdata),
        .o_av_address     (av_address),
        .o_av_read        (av_read),
        .o_av_write       (av_write),
        .o_av_writedata   (av_writedata),
        .i_av_readdata    (av_readdata),
        .i_av_waitrequest (av_waitrequest),
        .o_accept         (w_accept),
        .o_rdata          (w_rdata)
    );

    always_comb begin
        w_req       = 1'b0;
        w_req_write = 1'b0;
        w_addr      = c_addr_ctrl;
        w_wdata     = '0;
        case (r_state)
            S_CFG:       begin w_req = 1'b1; w_req_write = 1'b1; w_wdata = c_ctrl_on; end
            S_RD_STATUS: begin w_req = 1'b1; w_addr = c_addr_status; end
            S_CLR_UF:    begin w_req = 1'b1; w_req_write = 1'b1; w_addr = c_addr_status; w_wdata = c_uflow_clear; end
            S_RD_USEDW:  begin w_req = 1'b1; w_addr = c_addr_usedw; end
            S_RD_INT:    begin w_req = 1'b1; w_addr = c_addr_int; end
            S_RD_MODE:   begin w_req = 1'b1; w_addr = c_addr_mode; end
            S_CLR_INT:   begin w_req = 1'b1; w_req_write = 1'b1; w_addr = c_addr_int; w_wdata = {13'd0, r_pend, 1'b0}; end
            S_DISABLE:   begin w_req = 1'b1; w_req_write = 1'b1; w_wdata = c_ctrl_off; end
            default:     ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_CFG;
            S_CFG:       if (w_accept) w_next = S_RUN;
            S_RUN: begin
                if (stop || r_stop_pend)   w_next = S_DISABLE;
                else if (irq)              w_next = S_RD_INT;
                else if (r_cnt == c_cnt_max) w_next = S_RD_STATUS;
            end
            S_RD_STATUS: if (w_accept) w_next = (w_rdata[c_st_uflow] && (UNDERFLOW_CLEAR != 0)) ? S_CLR_UF : S_RD_USEDW;
            S_CLR_UF:    if (w_accept) w_next = S_RD_USEDW;
            S_RD_USEDW:  if (w_accept) w_next = S_RUN;
            S_RD_INT: begin
                if (w_accept) begin
                    if (w_pend == 2'b00) w_next = S_RUN;
                    else if (w_pend[0])  w_next = S_RD_MODE;
                    else                 w_next = S_CLR_INT;
                end
            end
            S_RD_MODE:   if (w_accept) w_next = S_CLR_INT;
            S_CLR_INT:   if (w_accept) w_next = S_RUN;
            S_DISABLE:   if (w_accept) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_stop_pend  <= 1'b0;
            r_running    <= 1'b0;
            r_fill       <= '0;
            r_genlocked  <= 1'b0;
            r_resync     <= 1'b0;
            r_mode       <= '0;
            r_mode_valid <= 1'b0;
            r_uf_cnt     <= 8'd0;
            r_pend       <= 2'b00;
        end else begin
            r_state      <= w_next;
            r_mode_valid <= 1'b0;
            // A stop outside RUN is remembered until the current sequence returns to RUN.
            if (stop && (r_state != S_RUN) && !((r_state == S_IDLE) && !start))
                r_stop_pend <= 1'b1;
            case (r_state)
                S_CFG: begin
                    if (w_accept) begin
                        r_running <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                S_RUN: begin
                    if (!(stop || r_stop_pend) && !irq && (r_cnt != c_cnt_max))
                        r_cnt <= r_cnt + 1'b1;
                end
                S_RD_STATUS: begin
                    if (w_accept) begin
                        r_genlocked <= w_rdata[c_st_genlocked];
                        r_resync    <= w_rdata[c_st_resync];
                    end
                end
                S_CLR_UF:   if (w_accept) r_uf_cnt <= sat_inc8(r_uf_cnt);
                S_RD_USEDW: begin
                    if (w_accept) begin
                        r_fill <= w_rdata[USED_WORDS_WIDTH-1:0];
                        r_cnt  <= '0;
                    end
                end
                S_RD_INT:   if (w_accept) r_pend <= w_pend;
                S_RD_MODE: begin
                    if (w_accept) begin
                        r_mode       <= w_rdata[NO_OF_MODES_INT-1:0];
                        r_mode_valid <= 1'b1;
                    end
                end
                S_DISABLE: begin
                    if (w_accept) begin
                        r_running   <= 1'b0;
                        r_stop_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign running         = r_running;
    assign fill_level      = r_fill;
    assign genlocked       = r_genlocked;
    assign resync          = r_resync;
    assign mode_match      = r_mode;
    assign mode_valid      = r_mode_valid;
    assign underflow_count = r_uf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_itc_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_itc_ctrl_master
// Description : Directed scoreboard bench for itc_ctrl_master with a simple
//               register-file slave model and controllable waitrequest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itc_ctrl_master;

    localparam int c_poll = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        irq = 1'b0;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        av_waitrequest = 1'b0;
    logic        running;
    logic [14:0] fill_level;
    logic        genlocked;
    logic        resync;
    logic [0:0]  mode_match;
    logic        mode_valid;
    logic [7:0]  underflow_count;

    logic [15:0] regs [0:4];

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] data;
    } xact_t;

    xact_t exp_q[$];
    int    n_pass = 0;
    int    n_fail = 0;
    int    n_total = 0;
    int    mv;

    always #5 clk = ~clk;

    assign av_readdata = (av_address <= 8'd4) ? regs[av_address[2:0]] : 16'h0000;

    itc_ctrl_master #(
        .INT_MASK         (2'b01),
        .GENLOCK_EN       (2'b00),
        .POLL_INTERVAL    (c_poll),
        .UNDERFLOW_CLEAR  (1),
        .USED_WORDS_WIDTH (15),
        .NO_OF_MODES_INT  (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .irq             (irq),
        .av_address      (av_address),
        .av_read         (av_read),
        .av_write        (av_write),
        .av_writedata    (av_writedata),
        .av_readdata     (av_readdata),
        .av_waitrequest  (av_waitrequest),
        .running         (running),
        .fill_level      (fill_level),
        .genlocked       (genlocked),
        .resync          (resync),
        .mode_match      (mode_match),
        .mode_valid      (mode_valid),
        .underflow_count (underflow_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [7:0] addr, input logic [15:0] data);
        xact_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        check(tag, exp_q.size(), 0);
    endtask

    // Raises irq, drops it once the reg2 read has been accepted, counts mode_valid cycles.
    task automatic irq_run(input int drop_at, output int mv_cnt);
        mv_cnt = 0;
        irq = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            tick();
            if (exp_q.size() <= drop_at) irq = 1'b0;
            if (mode_valid) mv_cnt++;
        end
        irq = 1'b0;
        check("irq_drain", exp_q.size(), 0);
    endtask

    // Bus monitor: every accepted command is popped from the scoreboard.
    always @(negedge clk) begin
        xact_t e;
        if (!rst && (av_read || av_write) && !av_waitrequest) begin
            check("xact_expected", 32'(exp_q.size() != 0), 32'd1);
            check("rd_wr_excl", 32'(av_read & av_write), 32'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("xact_wr", 32'(av_write), 32'(e.wr));
                check("xact_addr", 32'(av_address), 32'(e.addr));
                if (e.wr) check("xact_data", 32'(av_writedata), 32'(e.data));
            end
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) regs[i] = 16'h0000;

        // Reset state
        repeat (3) tick();
        check("rst_ctl", {running, av_read, av_write, av_address, av_writedata, genlocked, resync, mode_valid}, 0);
        check("rst_stat", {fill_level, underflow_count, mode_match}, 0);
        rst = 1'b0;
        tick();

        // start and stop together in IDLE: configure, then disable straight away
        push(1'b1, 8'd0, 16'h0003);
        push(1'b1, 8'd0, 16'h0002);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("cfg_cmd_first", {av_write, av_address, av_writedata}, {1'b1, 8'd0, 16'h0003});
        tick();
        check("cfg_running", running, 1);
        drain("start_stop_drain");
        check("start_stop_idle", running, 0);

        // stop in IDLE does nothing (monitor flags any command)
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (6) tick();
        check("stop_idle_running", running, 0);

        // Normal start, first poll sees an underflow
        regs[1] = 16'h0004; regs[3] = 16'd300;
        push(1'b1, 8'd0, 16'h0003);
        push(1'b0, 8'd1, 16'h0000);
        push(1'b1, 8'd1, 16'h0004);
        push(1'b0, 8'd3, 16'h0000);
        start = 1'b1; tick(); start = 1'b0;
        check("start_cmd", {av_write, av_address, av_writedata}, {1'b1, 8'd0, 16'h0003});
        tick();
        check("start_running", running, 1);
        drain("uf_poll_drain");
        check("uf_count_1", underflow_count, 1);
        check("fill_300", fill_level, 300);
        check("genlocked_0", genlocked, 0);

        // Poll without underflow, fill level truncated to 15 bits
        regs[1] = 16'h0009; regs[3] = 16'hFFFF;
        push(1'b0, 8'd1, 16'h0000);
        push(1'b0, 8'd3, 16'h0000);
        drain("poll2_drain");
        check("genlocked_1", genlocked, 1);
        check("resync_1", resync, 1);
        check("fill_trunc", fill_level, 15'h7FFF);
        check("uf_count_hold", underflow_count, 1);

        // Mode-change interrupt
        regs[1] = 16'h0000; regs[2] = 16'h0002; regs[4] = 16'h0001;
        push(1'b0, 8'd2, 16'h0000);
        push(1'b0, 8'd4, 16'h0000);
        push(1'b1, 8'd2, 16'h0002);
        irq_run(2, mv);
        check("mode_valid_pulses", mv, 1);
        check("mode_match", mode_match, 1);

        // irq arriving together with poll expiry: interrupt first, poll right after
        regs[2] = 16'h0004;
        push(1'b0, 8'd2, 16'h0000);
        push(1'b1, 8'd2, 16'h0004);
        push(1'b0, 8'd1, 16'h0000);
        push(1'b0, 8'd3, 16'h0000);
        repeat (c_poll - 1) tick();
        irq_run(3, mv);
        check("genlock_int_no_mode", mv, 0);

        // Spurious interrupt with nothing pending
        regs[2] = 16'h0000;
        push(1'b0, 8'd2, 16'h0000);
        irq_run(0, mv);

        // stop during a stalled RD_INT: sequence completes, then disable
        regs[2] = 16'h0002; regs[4] = 16'h0003;
        push(1'b0, 8'd2, 16'h0000);
        push(1'b0, 8'd4, 16'h0000);
        push(1'b1, 8'd2, 16'h0002);
        push(1'b1, 8'd0, 16'h0002);
        av_waitrequest = 1'b1; irq = 1'b1;
        tick();
        check("stall_rdint", {av_read, av_address}, {1'b1, 8'd2});
        stop = 1'b1; tick(); stop = 1'b0; irq = 1'b0;
        av_waitrequest = 1'b0;
        drain("stop_rdint_drain");
        check("stop_running", running, 0);
        repeat (8) tick();

        // Stalled CFG write: command stable for 4 cycles, one accept
        regs[1] = 16'h0004; regs[3] = 16'd5;
        av_waitrequest = 1'b1;
        push(1'b1, 8'd0, 16'h0003);
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) av_waitrequest = 1'b0;
            check("stall_cfg_stable", {av_write, av_address, av_writedata}, {1'b1, 8'd0, 16'h0003});
            if (k < 3) tick();
        end
        tick();
        check("stall_cfg_running", running, 1);

        // Forced underflow on every poll until the counter saturates
        for (int p = 0; p < 256; p++) begin
            push(1'b0, 8'd1, 16'h0000);
            push(1'b1, 8'd1, 16'h0004);
            push(1'b0, 8'd3, 16'h0000);
            drain("sat_poll_drain");
            if (p == 252) check("uf_count_254", underflow_count, 254);
        end
        check("uf_count_sat", underflow_count, 255);
        check("fill_5", fill_level, 5);

        // Stop, then reset in the middle of a stalled CFG write
        push(1'b1, 8'd0, 16'h0002);
        stop = 1'b1; tick(); stop = 1'b0;
        drain("stop_run_drain");
        av_waitrequest = 1'b1;
        push(1'b1, 8'd0, 16'h0003);
        start = 1'b1; tick(); start = 1'b0;
        check("cfg_before_rst", av_write, 1);
        rst = 1'b1;
        tick();
        check("midrst_ctl", {running, av_read, av_write, av_address, av_writedata, genlocked, resync, mode_valid}, 0);
        check("midrst_stat", {fill_level, underflow_count, mode_match}, 0);
        exp_q.delete();
        av_waitrequest = 1'b0;
        rst = 1'b0;
        repeat (8) tick();
        check("post_rst_idle", running, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
